// File: rtl/game_pkg.sv
// Shared types and helpers for the arcade game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    HIT   = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  typedef logic [15:0] bcd4_t;

  localparam bcd4_t BCD_MAX = 16'h9999;

  // +1 on four packed BCD digits with ripple carry; holds at 9999.
  function automatic bcd4_t bcd_inc_sat(input bcd4_t v);
    bcd4_t r;
    logic  c;
    r = v;
    c = 1'b1;
    if (v != BCD_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_bcd.sv
// Four-digit saturating BCD counter with synchronous clear (clear wins over inc).
module bcd_counter4
  import game_pkg::*;
(
  input  logic  clk,
  input  logic  resetN,
  input  logic  clr,
  input  logic  inc,
  output bcd4_t value
);

  bcd4_t r_value;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)  r_value <= '0;
    else if (clr) r_value <= '0;
    else if (inc) r_value <= bcd_inc_sat(r_value);
  end

  assign value = r_value;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer IDLE/PLAY/PAUSE/HIT/OVER with lives, BCD score and object reset/freeze.
// Optional high-score register enabled by defining GAME_HISCORE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int HIT_FRAMES  = 60,
  parameter int OVER_FRAMES = 180,
  parameter int BLINK_LOG2  = 3
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        v_sync,
  input  logic        collision,
  input  logic        score_inc,
  output logic        objects_resetN,
  output logic        objects_enable,
  output logic [2:0]  state,
  output logic [3:0]  lives,
  output logic [15:0] score_bcd,
  output logic        flash,
  output logic        game_over,
  output logic [15:0] hiscore_bcd
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_PLAY  = PLAY;
  localparam logic [2:0] S_PAUSE = PAUSE;
  localparam logic [2:0] S_HIT   = HIT;
  localparam logic [2:0] S_OVER  = OVER;

  localparam int FRAME_MAX = (HIT_FRAMES > OVER_FRAMES) ? HIT_FRAMES : OVER_FRAMES;
  localparam int CW        = $clog2(FRAME_MAX + 1);
  localparam logic [CW-1:0] HIT_LAST  = CW'(HIT_FRAMES - 1);
  localparam logic [CW-1:0] OVER_LAST = CW'(OVER_FRAMES - 1);

  logic          r_start_s, r_start_p, r_pause_s, r_pause_p, r_vs_s, r_vs_p;
  logic          w_start_edge, w_pause_edge, w_frame;
  logic [2:0]    r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [3:0]    r_lives, w_nxt_lives;
  logic          r_latch, r_obj_rstn, r_enable, r_flash, r_game_over;
  logic          w_respawn, w_score_clr, w_score_inc;
  bcd4_t         w_score;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_start_s <= 1'b0; r_start_p <= 1'b0;
      r_pause_s <= 1'b0; r_pause_p <= 1'b0;
      r_vs_s    <= 1'b0; r_vs_p    <= 1'b0;
    end else begin
      r_start_s <= start_btn; r_start_p <= r_start_s;
      r_pause_s <= pause_btn; r_pause_p <= r_pause_s;
      r_vs_s    <= v_sync;    r_vs_p    <= r_vs_s;
    end
  end

  assign w_start_edge = r_start_s & ~r_start_p;
  assign w_pause_edge = r_pause_s & ~r_pause_p;
  assign w_frame      = ~r_vs_s & r_vs_p;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_lives = r_lives;
    w_respawn   = 1'b0;
    w_score_clr = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_edge) begin
        w_nxt_state = S_PLAY;
        w_nxt_lives = 4'(LIVES_INIT);
        w_score_clr = 1'b1;
      end
      // A collision frame outranks a pause edge arriving in the same cycle.
      S_PLAY: if (w_frame && r_latch) begin
        w_nxt_lives = r_lives - 4'd1;
        w_nxt_cnt   = '0;
        w_nxt_state = (r_lives == 4'd1) ? S_OVER : S_HIT;
      end else if (w_pause_edge) begin
        w_nxt_state = S_PAUSE;
      end
      S_PAUSE: if (w_pause_edge) w_nxt_state = S_PLAY;
      S_HIT: if (w_frame) begin
        if (r_cnt == HIT_LAST) begin
          w_nxt_state = S_PLAY;
          w_nxt_cnt   = '0;
          w_respawn   = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_OVER: if (w_frame) begin
        if (r_cnt == OVER_LAST) w_nxt_state = S_IDLE;
        else                    w_nxt_cnt   = r_cnt + 1'b1;
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_lives     <= 4'(LIVES_INIT);
      r_latch     <= 1'b0;
      r_obj_rstn  <= 1'b0;
      r_enable    <= 1'b0;
      r_flash     <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_lives     <= w_nxt_lives;
      if (w_frame)                            r_latch <= 1'b0;
      else if (collision && r_state == S_PLAY) r_latch <= 1'b1;
      r_obj_rstn  <= (w_nxt_state != S_IDLE) && !w_respawn;
      r_enable    <= (w_nxt_state == S_PLAY);
      r_flash     <= (w_nxt_state == S_HIT) ? w_nxt_cnt[BLINK_LOG2] : 1'b0;
      r_game_over <= (w_nxt_state == S_OVER);
    end
  end

  assign w_score_inc = score_inc && (r_state == S_PLAY);

  bcd_counter4 u_score (
    .clk    (clk),
    .resetN (resetN),
    .clr    (w_score_clr),
    .inc    (w_score_inc),
    .value  (w_score)
  );

`ifdef GAME_HISCORE_EN
  bcd4_t r_hiscore, w_final_score;

  // Includes a point scored in the very cycle the game ends.
  assign w_final_score = w_score_inc ? bcd_inc_sat(w_score) : w_score;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_hiscore <= '0;
    else if (r_state == S_PLAY && w_nxt_state == S_OVER && w_final_score > r_hiscore)
      r_hiscore <= w_final_score;
  end

  assign hiscore_bcd = r_hiscore;
`else
  assign hiscore_bcd = 16'h0000;
`endif

  assign objects_resetN = r_obj_rstn;
  assign objects_enable = r_enable;
  assign state          = r_state;
  assign lives          = r_lives;
  assign score_bcd      = w_score;
  assign flash          = r_flash;
  assign game_over      = r_game_over;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: vector table, directed game sequences and random play vs a reference model.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start_btn = 1'b0, pause_btn = 1'b0, v_sync = 1'b1, collision = 1'b0, score_inc = 1'b0;
  logic        objects_resetN, objects_enable, flash, game_over;
  logic [2:0]  state;
  logic [3:0]  lives;
  logic [15:0] score_bcd, hiscore_bcd;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk(clk), .resetN(resetN), .start_btn(start_btn), .pause_btn(pause_btn),
    .v_sync(v_sync), .collision(collision), .score_inc(score_inc),
    .objects_resetN(objects_resetN), .objects_enable(objects_enable), .state(state),
    .lives(lives), .score_bcd(score_bcd), .flash(flash), .game_over(game_over),
    .hiscore_bcd(hiscore_bcd)
  );

`ifdef GAME_HISCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_HIT = 3, M_OVER = 4;

  int n_checks = 0;
  int n_errors = 0;
  int n_rstn_low = 0;

  // Reference model: game rules in integer terms.
  int m_state, m_lives, m_score, m_hs, m_cnt;
  bit m_latch, m_respawn;
  bit h_st1, h_st2, h_pa1, h_pa2, h_vs1, h_vs2;

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_lives = 3; m_score = 0; m_hs = 0; m_cnt = 0;
    m_latch = 0; m_respawn = 0;
    h_st1 = 0; h_st2 = 0; h_pa1 = 0; h_pa2 = 0; h_vs1 = 0; h_vs2 = 0;
  endtask

  task automatic model_step(input bit st, input bit pa, input bit vs, input bit co, input bit si);
    bit se, pe, fe;
    int old;
    se = h_st1 & ~h_st2; pe = h_pa1 & ~h_pa2; fe = ~h_vs1 & h_vs2;
    h_st2 = h_st1; h_st1 = st; h_pa2 = h_pa1; h_pa1 = pa; h_vs2 = h_vs1; h_vs1 = vs;
    old = m_state;
    m_respawn = 0;
    if (old == M_PLAY && si) m_score = (m_score < 9999) ? m_score + 1 : 9999;
    case (old)
      M_IDLE: if (se) begin m_state = M_PLAY; m_lives = 3; m_score = 0; end
      M_PLAY: begin
        if (fe && m_latch) begin
          m_lives = m_lives - 1;
          m_cnt = 0;
          if (m_lives == 0) begin
            m_state = M_OVER;
            if (HS_EN && m_score > m_hs) m_hs = m_score;
          end else m_state = M_HIT;
        end else if (pe) m_state = M_PAUSE;
      end
      M_PAUSE: if (pe) m_state = M_PLAY;
      M_HIT: if (fe) begin
        if (m_cnt == 59) begin m_state = M_PLAY; m_respawn = 1; end
        else m_cnt++;
      end
      M_OVER: if (fe) begin
        if (m_cnt == 179) m_state = M_IDLE;
        else m_cnt++;
      end
      default: m_state = M_IDLE;
    endcase
    if (fe) m_latch = 0;
    else if (co && old == M_PLAY) m_latch = 1;
  endtask

  task automatic compare_model();
    chk("state", 32'(state), m_state);
    chk("lives", 32'(lives), m_lives);
    chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
    chk("enable", 32'(objects_enable), 32'(m_state == M_PLAY));
    chk("obj_rstn", 32'(objects_resetN), 32'((m_state != M_IDLE) && !m_respawn));
    chk("flash", 32'(flash), 32'((m_state == M_HIT) ? ((m_cnt >> 3) & 1) : 0));
    chk("game_over", 32'(game_over), 32'(m_state == M_OVER));
    chk("hiscore", 32'(hiscore_bcd), 32'(to_bcd(m_hs)));
    if (!objects_resetN) n_rstn_low++;
  endtask

  // Inputs are applied just after an edge, sampled by the next one, checked 1 ns later.
  task automatic cycle(input bit st, input bit pa, input bit vs, input bit co, input bit si);
    start_btn = st; pause_btn = pa; v_sync = vs; collision = co; score_inc = si;
    @(posedge clk);
    model_step(st, pa, vs, co, si);
    #1;
    compare_model();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 0, 0, 0);
      repeat (3) cycle(0, 0, 1, 0, 0);
    end
  endtask

  task automatic press_start();
    cycle(1, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
  endtask

  task automatic press_pause();
    cycle(0, 1, 1, 0, 0); cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
  endtask

  task automatic take_hit();
    cycle(0, 0, 1, 1, 0);
    frames(1);
  endtask

  task automatic add_points(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 1, 0, 1);
  endtask

  task automatic apply_reset();
    start_btn = 0; pause_btn = 0; v_sync = 1; collision = 0; score_inc = 0;
    #2 resetN = 1'b0;
    #1;
    model_reset();
    chk("rst_state", 32'(state), M_IDLE);
    chk("rst_flash", 32'(flash), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_rstn", 32'(objects_resetN), 0);
    chk("rst_enable", 32'(objects_enable), 0);
    chk("rst_score", 32'(score_bcd), 0);
    chk("rst_over", 32'(game_over), 0);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  typedef struct {
    bit st, pa, vs, co, si;
    logic [2:0] e_state;
    logic [3:0] e_lives;
    bit e_en, e_rstn;
  } vec_t;

  vec_t tbl[9];
  logic [15:0] hs_exp;

  initial begin
    tbl[0] = '{0, 0, 1, 0, 0, 3'd0, 4'd3, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 0, 3'd0, 4'd3, 0, 0};
    tbl[2] = '{1, 0, 1, 0, 0, 3'd1, 4'd3, 1, 1};
    tbl[3] = '{0, 0, 1, 0, 0, 3'd1, 4'd3, 1, 1};
    tbl[4] = '{0, 0, 1, 1, 0, 3'd1, 4'd3, 1, 1};
    tbl[5] = '{0, 0, 0, 0, 0, 3'd1, 4'd3, 1, 1};
    tbl[6] = '{0, 0, 1, 0, 0, 3'd3, 4'd2, 0, 1};
    tbl[7] = '{0, 1, 1, 0, 0, 3'd3, 4'd2, 0, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 3'd3, 4'd2, 0, 1};
    hs_exp = HS_EN ? 16'h0042 : 16'h0000;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_state", 32'(state), M_IDLE);
    chk("init_lives", 32'(lives), 3);
    chk("init_rstn", 32'(objects_resetN), 0);
    chk("init_score", 32'(score_bcd), 0);
    chk("init_hiscore", 32'(hiscore_bcd), 0);
    resetN = 1'b1;

    // Start, one collision, frame event -> HIT; pause ignored in HIT.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].st, tbl[i].pa, tbl[i].vs, tbl[i].co, tbl[i].si);
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("vec%0d_lives", i), 32'(lives), 32'(tbl[i].e_lives));
      chk($sformatf("vec%0d_en", i), 32'(objects_enable), 32'(tbl[i].e_en));
      chk($sformatf("vec%0d_rstn", i), 32'(objects_resetN), 32'(tbl[i].e_rstn));
    end

    n_rstn_low = 0;
    frames(59);
    chk("hit_hold_state", 32'(state), M_HIT);
    frames(1);
    chk("respawn_pulse", n_rstn_low, 1);
    chk("hit_exit_state", 32'(state), M_PLAY);

    add_points(12);
    chk("score_12", 32'(score_bcd), 32'h0012);

    press_pause();
    chk("pause_state", 32'(state), M_PAUSE);
    chk("pause_enable", 32'(objects_enable), 0);
    cycle(0, 0, 1, 1, 0);
    frames(2);
    chk("pause_lives", 32'(lives), 2);
    press_pause();
    chk("unpause_state", 32'(state), M_PLAY);

    add_points(30);
    chk("score_42", 32'(score_bcd), 32'h0042);
    take_hit();
    frames(60);
    take_hit();
    chk("over_state", 32'(state), M_OVER);
    chk("over_flag", 32'(game_over), 1);
    chk("over_hiscore", 32'(hiscore_bcd), 32'(hs_exp));
    press_start();
    chk("over_ignores_start", 32'(state), M_OVER);
    frames(179);
    chk("over_hold", 32'(state), M_OVER);
    frames(1);
    chk("over_to_idle", 32'(state), M_IDLE);
    chk("idle_score_hold", 32'(score_bcd), 32'h0042);

    press_start();
    chk("restart_lives", 32'(lives), 3);
    chk("restart_score", 32'(score_bcd), 0);
    add_points(10);
    take_hit(); frames(60);
    take_hit(); frames(60);
    take_hit();
    chk("game2_over", 32'(state), M_OVER);
    chk("game2_hiscore", 32'(hiscore_bcd), 32'(hs_exp));
    frames(180);

    for (int i = 0; i < 4000; i++)
      cycle(bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 47) == 0),
            bit'($urandom_range(0, 5) != 0), bit'($urandom_range(0, 39) == 0),
            bit'($urandom_range(0, 1)));

    apply_reset();
    press_start();
    add_points(9999);
    chk("score_9999", 32'(score_bcd), 32'h9999);
    add_points(3);
    chk("score_sat", 32'(score_bcd), 32'h9999);

    apply_reset();
    press_start();
    take_hit();
    frames(30);
    chk("mid_hit_state", 32'(state), M_HIT);
    apply_reset();
    press_start();
    take_hit();
    frames(59);
    chk("post_rst_hit_hold", 32'(state), M_HIT);
    frames(1);
    chk("post_rst_hit_exit", 32'(state), M_PLAY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the arcade template. Owns the IDLE/PLAY/PAUSE/HIT/OVER flow. Drives the shared reset and freeze of all moving objects (Intel/Ghost units). Consumes debounced buttons, the per-pixel collision term and VGA v_sync; tracks lives and a 4-digit BCD score for the 7-seg/overlay datapath.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..15)
HIT_FRAMES, 60, frames the scene stays frozen after a hit
OVER_FRAMES, 180, frames spent in OVER before returning to IDLE
BLINK_LOG2, 3, flash toggles every 2**BLINK_LOG2 frames during HIT

Ports:
clk  in  1  system clock (clk_25 domain)
resetN  in  1  async active-low reset
start_btn  in  1  debounced Start level, active-high
pause_btn  in  1  debounced Select level, active-high
v_sync  in  1  VGA v_sync (active-low); its 1->0 edge is the frame event
collision  in  1  per-pixel collision level (draw_a && draw_b)
score_inc  in  1  one-cycle pulse; add 1 to score
objects_resetN  out  1  active-low reset to all object units
objects_enable  out  1  1 = objects may move; 0 = frozen
state  out  3  current state encoding (game_pkg)
lives  out  4  remaining lives
score_bcd  out  16  4 BCD digits, [15:12] most significant
flash  out  1  blink for sprite hide during HIT
game_over  out  1  high while in OVER
hiscore_bcd  out  16  high score (see Optional Feature)

Behaviour:
- Reset (async, resetN=0) forces state=IDLE, objects_resetN=0, objects_enable=0, lives=LIVES_INIT, score=0, flash=0, game_over=0, hiscore=0, frame counter=0, collision latch=0, edge-detect flops=0. Reset may assert in any state; outputs follow immediately.
- start_btn, pause_btn and v_sync are each registered once; action is taken on the edge (rising for buttons, falling for v_sync). Outputs are registered, so the response appears 1 clk after the edge is detected.
- Collision latch: set on any cycle collision=1 while in PLAY. Evaluated and cleared on the frame event.
- IDLE: objects_resetN=0, enable=0. On start edge go to PLAY; lives:=LIVES_INIT, score:=0.
- PLAY: objects_resetN=1, enable=1.
  - On frame event with latch set: lives:=lives-1. Go to OVER if the new value is 0, else go to HIT. Frame counter:=0.
  - Else, on pause edge: go to PAUSE.
- PAUSE: enable=0, objects_resetN=1. Pause edge returns to PLAY. Collision is not latched.
- HIT: enable=0. Frame counter increments on each frame event. flash = counter[BLINK_LOG2].
  - When counter reaches HIT_FRAMES-1 on a frame event: objects_resetN=0 for exactly 1 clk (respawn), flash:=0, go to PLAY.
- OVER: game_over=1, enable=0. Counts frame events. Start edges are ignored.
  - At OVER_FRAMES-1: go to IDLE. lives and score hold until the next start.
- Score: a BCD +1 is accepted only when score_inc=1 in PLAY. Each digit wraps 9->0 with carry. Saturates at 9999 and holds.
- Simultaneous events:
  - Collision frame event and pause edge in the same cycle: HIT wins; the pause is dropped.
  - score_inc in the same cycle as a collision frame event: the point counts.
  - Start and pause edges in the same cycle in IDLE: start is taken.
- Frame counter width: $clog2(max(HIT_FRAMES,OVER_FRAMES)+1).
- Unused state encodings recover to IDLE.

Optional Feature:
GAME_HISCORE_EN
- Defined: hiscore register is instantiated. On entry to OVER, if score > hiscore then hiscore:=score. hiscore_bcd shows it. Survives games, cleared only by resetN.
- Undefined: no register; hiscore_bcd tied to 16'h0000. Port list is unchanged.

Decomposition:
- Package game_pkg holds:
  - state enum game_state_t (IDLE=0, PLAY=1, PAUSE=2, HIT=3, OVER=4)
  - bcd4_t typedef (logic [15:0])
  - constant BCD_MAX=16'h9999
- Sub-module bcd_counter4: clk, resetN, clr, inc → 4-digit BCD value, saturating. It is reused for the score; the hiscore compare is done in the top block.

Test Plan:
1. Reset, then start edge → PLAY 1 clk later. objects_resetN=1, enable=1, lives=3, score=0000.
2. In PLAY, 12 score_inc pulses → score_bcd=16'h0012. Preload near 9999 and apply 3 pulses → score holds 16'h9999.
3. Collision for 1 clk mid-frame → no change until the v_sync falling edge; then lives=2 and state=HIT. After 60 frame events, a 1-clk objects_resetN low pulse, then PLAY.
4. Pause edge in PLAY → enable=0. A collision during PAUSE is ignored (lives unchanged). A second pause edge → PLAY.
5. Three collisions → OVER, game_over=1, a start edge is ignored. After 180 frames → IDLE. With GAME_HISCORE_EN and score 0042, hiscore_bcd=0042. A following game ending at 0010 leaves it at 0042.
6. resetN asserted mid-HIT (frame counter=30) → immediate IDLE, flash=0, lives=3, counter=0.
